// File: rtl/mont_final_sub.sv
// mont_final_sub: final conditional subtraction for the radix-4 Montgomery
// multiplier. Reduces X (< 2M) to R = X mod M by running X - M serially,
// W bits per cycle, through a single narrow subtractor. The sign of the
// full-width difference is the borrow left over after the last chunk.
// Optional feature macro: FINALSUB_RANGE_CHECK_EN adds a range_err output
// that flags X >= 2M using a second chunk subtractor.
module mont_final_sub #(
    parameter int N = 1024,
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N:0]   in_x,
    input  logic [N-1:0] in_m,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         sub_taken
`ifdef FINALSUB_RANGE_CHECK_EN
    ,
    output logic         range_err
`endif
);

    localparam int K  = N / W + 1;
    localparam int DW = K * W;
    localparam int CW = $clog2(K);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [1:0] {IDLE, SUB, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          borrow;
    logic [DW-1:0] xs;
    logic [DW-1:0] ms;
    logic [N-1:0]  xc;
    // Holds the low K-1 difference chunks; the top chunk is never part of R.
    logic [N-1:0]  ds;
    logic [W:0]    diff;
    logic          accept;

    assign accept = (state == IDLE) && in_valid && in_ready;

    // Current chunk of X - M with the running borrow; bit W is the new borrow.
    always_comb begin
        diff = {1'b0, xs[W-1:0]} - {1'b0, ms[W-1:0]} - {{W{1'b0}}, borrow};
    end

`ifdef FINALSUB_RANGE_CHECK_EN
    logic       borrow2;
    logic       m2_carry;
    logic [W:0] diff2;

    // Current chunk of X - 2M; 2M's chunk takes the top bit of M's previous chunk.
    always_comb begin
        diff2 = {1'b0, xs[W-1:0]} - {1'b0, ms[W-2:0], m2_carry} - {{W{1'b0}}, borrow2};
    end
`endif

    // Control FSM: accept, chunk sequencing, result capture and output hold.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            sub_taken <= 1'b0;
            cnt       <= '0;
            borrow    <= 1'b0;
`ifdef FINALSUB_RANGE_CHECK_EN
            borrow2   <= 1'b0;
            m2_carry  <= 1'b0;
            range_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= '0;
                        borrow   <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= SUB;
`ifdef FINALSUB_RANGE_CHECK_EN
                        borrow2  <= 1'b0;
                        m2_carry <= 1'b0;
`endif
                    end
                end
                SUB: begin
                    borrow <= diff[W];
                    cnt    <= cnt + 1'b1;
`ifdef FINALSUB_RANGE_CHECK_EN
                    borrow2  <= diff2[W];
                    m2_carry <= ms[W-1];
`endif
                    if (cnt == LAST) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        // A final borrow means X < M, so X itself is already reduced.
                        result    <= diff[W] ? xc : ds;
                        sub_taken <= ~diff[W];
`ifdef FINALSUB_RANGE_CHECK_EN
                        range_err <= ~diff2[W];
`endif
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
`ifdef FINALSUB_RANGE_CHECK_EN
                        range_err <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand and difference shift registers; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            xs <= {{(DW-N-1){1'b0}}, in_x};
            ms <= {{(DW-N){1'b0}}, in_m};
            xc <= in_x[N-1:0];
        end else if (state == SUB) begin
            xs <= xs >> W;
            ms <= ms >> W;
            ds <= {diff[W-1:0], ds[N-1:W]};
        end
    end

endmodule
